half_duplex_bus_master: RTL

- Direction owner for a shared tristate bus (ctrl=1: this side drives; ctrl=0: peer drives), i.e. the end that generates `ctrl` for a passive tristate transceiver.
- Moves WIDTH-bit words from a local TX stream onto the bus, and samples peer words into a local RX stream.
- Inserts turnaround cycles so the two drivers never overlap.
- Arbitrates direction with a burst limit so that neither direction starves.

---
 rtl/half_duplex_bus_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/half_duplex_bus_master.sv
// Half-duplex bus master: owns direction (ctrl) of a shared tristate bus, streams TX words
// out, samples peer words in, inserts turnaround gaps and enforces a per-direction burst
// limit so neither side starves.
module half_duplex_bus_master #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned MAX_BURST   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_req,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             ctrl,
    inout  wire  [WIDTH-1:0] bus_io
);

    typedef enum logic [1:0] {StTx, StTurnRx, StRx, StTurnTx} state_e;

    state_e           state_q, state_d;
    logic [3:0]       turn_q, turn_d;
    logic [7:0]       burst_q, burst_d;
    logic             oe_q, oe_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;

    logic             burst_hit;
    logic             turn_done;
    logic [7:0]       burst_inc;

    assign burst_hit = (burst_q >= 8'(MAX_BURST));
    assign turn_done = (turn_q == 4'(TURN_CYCLES - 1));
    // Saturating increment keeps the limit comparison valid on long idle-free runs.
    assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

    // Next-state, datapath updates and direction/handshake outputs.
    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        burst_d    = burst_q;
        oe_d       = 1'b0;
        out_d      = out_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        tx_ready   = 1'b0;
        ctrl       = 1'b1;
        unique case (state_q)
            StTx: begin
                if (rx_req && (!tx_valid || burst_hit)) begin
                    state_d = StTurnRx;
                    turn_d  = 4'd0;
                    burst_d = 8'd0;
                end else begin
                    tx_ready = 1'b1;
                    if (tx_valid) begin
                        out_d   = tx_data;
                        oe_d    = 1'b1;
                        burst_d = burst_inc;
                    end
                end
            end
            StTurnRx: begin
                if (turn_done) begin
                    state_d = StRx;
                    turn_d  = 4'd0;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            StRx: begin
                ctrl = 1'b0;
                if (tx_valid && (!rx_req || burst_hit)) begin
                    state_d = StTurnTx;
                    turn_d  = 4'd0;
                    burst_d = 8'd0;
                end else if (rx_req) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = bus_io;
                    burst_d    = burst_inc;
                end
            end
            StTurnTx: begin
                if (turn_done) begin
                    state_d = StTx;
                    turn_d  = 4'd0;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            default: state_d = StTx;
        endcase
        // No handshake may complete on a reset edge.
        if (rst) begin
            tx_ready = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StTx;
            turn_q     <= 4'd0;
            burst_q    <= 8'd0;
            oe_q       <= 1'b0;
            out_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            burst_q    <= burst_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    // oe is only ever set from the TX state, so it cannot be high while ctrl=0.
    assign bus_io   = oe_q ? out_q : {WIDTH{1'bz}};

endmodule
